// File: rtl/i8008_mem_responder.sv
// Bus partner for i8008_core: captures the two address bytes, then answers the cycle
// from local memory, the I/O port space or the interrupt jam byte.
module i8008_mem_responder #(
   parameter int         MEM_DEPTH   = 16384,
   parameter int         WAIT_CYCLES = 0,
   parameter logic [7:0] JAM_INSTR   = 8'h05
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  state,
   input  logic        Sync,
   input  logic [7:0]  D_out,
   output logic [7:0]  D_in,
   output logic        READY,
   output logic        INTR,
   input  logic        intr_req,
   input  logic        ld_we,
   input  logic [13:0] ld_addr,
   input  logic [7:0]  ld_data,
   input  logic [7:0]  io_in_data,
   output logic [4:0]  io_port,
   output logic        io_wr,
   output logic [7:0]  io_data
);

   // state   | meaning
   // IDLE    | waiting for T1/T1I (low address byte)
   // GOT_LO  | low byte held, waiting for T2 (cycle type + high byte)
   // DELAY   | counting extra wait cycles before READY
   // RESPOND | READY high, D_in valid, waiting for T3

   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [2:0] ST_T1  = 3'd0;
   localparam logic [2:0] ST_T1I = 3'd1;
   localparam logic [2:0] ST_T2  = 3'd2;
   localparam logic [2:0] ST_T3  = 3'd4;
   localparam logic [1:0] CYC_PCI = 2'b00;
   localparam logic [1:0] CYC_PCC = 2'b01;
   localparam logic [1:0] CYC_PCR = 2'b10;
   localparam logic [1:0] CYC_PCW = 2'b11;

   typedef enum logic [1:0] {IDLE, GOT_LO, DELAY, RESPOND} fsm_t;

   logic [7:0]    mem [MEM_DEPTH];
   fsm_t          fsm;
   logic [7:0]    addr_lo;
   logic [5:0]    addr_hi;
   logic [1:0]    cyc;
   logic [3:0]    cnt;
   logic          pending;
   logic          jam;
   logic          intr_q;
   logic [13:0]   addr;
   logic [AW-1:0] mem_idx;
   logic          is_t1;
   logic          pcw_commit;
   logic          intr_rise;
   logic          is_out;
   logic [7:0]    rd_data;
   logic          unused_bits;

   assign addr        = {addr_hi, addr_lo};
   assign mem_idx     = addr[AW-1:0];
   assign is_t1       = (state == ST_T1) || (state == ST_T1I);
   assign pcw_commit  = (fsm == RESPOND) && (state == ST_T3) && (cyc == CYC_PCW);
   assign intr_rise   = intr_req & ~intr_q;
   // ports 0..7 are inputs, 8..31 outputs
   assign is_out      = (addr_hi[5:4] != 2'b00);
   assign unused_bits = ^{Sync, ld_addr, addr};

   always_comb begin
      rd_data = 8'h00;
      case (cyc)
         CYC_PCI: rd_data = jam ? JAM_INSTR : mem[mem_idx];
         CYC_PCR: rd_data = mem[mem_idx];
         CYC_PCC: rd_data = is_out ? 8'h00 : io_in_data;
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm     <= IDLE;
         D_in    <= 8'h00;
         READY   <= 1'b0;
         INTR    <= 1'b0;
         io_wr   <= 1'b0;
         io_port <= 5'd0;
         io_data <= 8'h00;
         pending <= 1'b0;
         jam     <= 1'b0;
         intr_q  <= 1'b0;
         addr_lo <= 8'h00;
         addr_hi <= 6'd0;
         cyc     <= 2'b00;
         cnt     <= 4'd0;
      end else begin
         io_wr  <= 1'b0;
         intr_q <= intr_req;
         if (intr_rise && !jam) begin
            pending <= 1'b1;
            INTR    <= 1'b1;
         end
         case (fsm)
            IDLE, GOT_LO: begin
               if (is_t1) begin
                  addr_lo <= D_out;
                  fsm     <= GOT_LO;
                  // T1I acknowledges the interrupt; it wins over a same-edge request
                  if (state == ST_T1I) begin
                     jam     <= 1'b1;
                     pending <= 1'b0;
                     INTR    <= 1'b0;
                  end
               end else if ((fsm == GOT_LO) && (state == ST_T2)) begin
                  cyc     <= D_out[7:6];
                  addr_hi <= D_out[5:0];
                  cnt     <= 4'(WAIT_CYCLES);
                  if (D_out[7:6] == CYC_PCC) io_port <= D_out[5:1];
                  fsm     <= DELAY;
               end
            end
            DELAY: begin
               if (cnt == 4'd0) begin
                  READY <= 1'b1;
                  D_in  <= rd_data;
                  fsm   <= RESPOND;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESPOND: begin
               if (state == ST_T3) begin
                  READY <= 1'b0;
                  fsm   <= IDLE;
                  if (cyc == CYC_PCI) jam <= 1'b0;
                  if ((cyc == CYC_PCC) && is_out) begin
                     io_data <= addr_lo;
                     io_wr   <= 1'b1;
                  end
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   // core write is ordered after the preload port so it wins on a collision
   always_ff @(posedge clk) begin
      if (ld_we)      mem[ld_addr[AW-1:0]] <= ld_data;
      if (pcw_commit) mem[mem_idx]         <= D_out;
   end

endmodule

// File: tb/tb_i8008_mem_responder.sv
// Bench acting as i8008 core against two responders (0 and 3 wait cycles) sharing one bus.
module tb_i8008_mem_responder;

   localparam logic [2:0] T1 = 3'd0, T1I = 3'd1, T2 = 3'd2, TW = 3'd3;
   localparam logic [2:0] T3 = 3'd4, T4 = 3'd5, T5 = 3'd6, STOP = 3'd7;
   localparam int WS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  state = STOP;
   logic [7:0]  D_out = 8'h00;
   logic        intr_req = 1'b0;
   logic        ld_we = 1'b0;
   logic [13:0] ld_addr = 14'd0;
   logic [7:0]  ld_data = 8'h00;
   logic [7:0]  io_in_data = 8'h00;

   logic [7:0] d_in0, d_in3, io_data0, io_data3;
   logic       ready0, ready3, intr0, intr3, io_wr0, io_wr3;
   logic [4:0] io_port0, io_port3;

   i8008_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .state(state), .Sync(1'b0), .D_out(D_out),
      .D_in(d_in0), .READY(ready0), .INTR(intr0), .intr_req(intr_req),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .io_in_data(io_in_data),
      .io_port(io_port0), .io_wr(io_wr0), .io_data(io_data0));

   i8008_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .state(state), .Sync(1'b0), .D_out(D_out),
      .D_in(d_in3), .READY(ready3), .INTR(intr3), .intr_req(intr_req),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .io_in_data(io_in_data),
      .io_port(io_port3), .io_wr(io_wr3), .io_data(io_data3));

   always #5 clk = ~clk;

   // model: memory image, interrupt flags, and expected outputs after the next edge
   logic [7:0] m_mem [16384];
   bit         m_pending = 1'b0;
   bit         m_jam = 1'b0;
   bit         e_ready0 = 1'b0, e_ready3 = 1'b0, e_io_wr = 1'b0;
   logic [7:0] e_din0 = 8'h00, e_din3 = 8'h00;
   bit         e_din0_v = 1'b1, e_din3_v = 1'b1;
   bit         chk_en = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         io_wr_pulses = 0;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         check8("ready_w0", {7'd0, ready0}, {7'd0, e_ready0});
         check8("ready_w3", {7'd0, ready3}, {7'd0, e_ready3});
         check8("intr_w0", {7'd0, intr0}, {7'd0, m_pending});
         check8("intr_w3", {7'd0, intr3}, {7'd0, m_pending});
         check8("io_wr_w0", {7'd0, io_wr0}, {7'd0, e_io_wr});
         check8("io_wr_w3", {7'd0, io_wr3}, {7'd0, e_io_wr});
         if (e_din0_v) check8("d_in_w0", d_in0, e_din0);
         if (e_din3_v) check8("d_in_w3", d_in3, e_din3);
         if (io_wr3) io_wr_pulses++;
      end
   end

   function automatic logic [7:0] expected_read(input logic [7:0] hi, input logic [7:0] lo);
      logic [13:0] a;
      logic [4:0]  port;
      a    = {hi[5:0], lo};
      port = hi[5:1];
      case (hi[7:6])
         2'b00:   return m_jam ? 8'h05 : m_mem[a];
         2'b10:   return m_mem[a];
         2'b11:   return 8'h00;
         default: return (port < 5'd8) ? io_in_data : 8'h00;
      endcase
   endfunction

   task automatic preload(input logic [13:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_we = 1'b1; ld_addr = a; ld_data = d; m_mem[a] = d;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   task automatic pulse_intr();
      @(negedge clk);
      intr_req = 1'b1;
      if (!m_jam) m_pending = 1'b1;
      @(negedge clk);
      intr_req = 1'b0;
   endtask

   // ld_when: 0 none, 2 during the second wait cycle, 9 on the T3 edge
   task automatic bus_cycle(input bit t1i, input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] wdata, input bit intr_at_t2, input int ld_when,
                            input logic [7:0] ld_val, output logic [7:0] got3);
      logic [13:0] a;
      logic [7:0]  exp_rd;
      bit          out_port;
      int          nwait;
      a        = {hi[5:0], lo};
      out_port = (hi[7:6] == 2'b01) && (hi[5:1] >= 5'd8);
      got3     = 8'h00;
      @(negedge clk);
      state = t1i ? T1I : T1; D_out = lo;
      e_ready0 = 1'b0; e_ready3 = 1'b0; e_io_wr = 1'b0; e_din0_v = 1'b0; e_din3_v = 1'b0;
      if (t1i) begin m_pending = 1'b0; m_jam = 1'b1; end
      @(negedge clk);
      state = T2; D_out = hi;
      if (intr_at_t2) begin intr_req = 1'b1; if (!m_jam) m_pending = 1'b1; end
      nwait = 0;
      while (1) begin
         @(negedge clk);
         intr_req = 1'b0; ld_we = 1'b0;
         if (ready3 === 1'b1 || nwait >= 20) break;
         state = TW; nwait++;
         exp_rd = expected_read(hi, lo);
         if (nwait == 1)  begin e_ready0 = 1'b1; e_din0 = exp_rd; e_din0_v = !out_port; end
         if (nwait == WS) begin e_ready3 = 1'b1; e_din3 = exp_rd; e_din3_v = !out_port; end
         if (ld_when == 2 && nwait == 2) begin
            ld_we = 1'b1; ld_addr = a; ld_data = ld_val; m_mem[a] = ld_val;
         end
      end
      check8("wait_count", 8'(nwait), 8'(WS));
      got3 = d_in3;
      state = T3; D_out = wdata;
      e_ready0 = 1'b0; e_ready3 = 1'b0; e_din0_v = 1'b0; e_din3_v = 1'b0; e_io_wr = out_port;
      if (ld_when == 9) begin
         ld_we = 1'b1; ld_addr = a; ld_data = ld_val; m_mem[a] = ld_val;
      end
      if (hi[7:6] == 2'b11) m_mem[a] = wdata;
      if (hi[7:6] == 2'b00) m_jam = 1'b0;
      @(negedge clk);
      ld_we = 1'b0; state = T4; e_io_wr = 1'b0;
      @(negedge clk);
      state = T5;
   endtask

   logic [7:0] got;

   initial begin
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check8("rst_d_in", d_in3, 8'h00);
      check8("rst_ready", {7'd0, ready3}, 8'h00);
      check8("rst_intr", {7'd0, intr3}, 8'h00);
      check8("rst_io_port", {3'd0, io_port3}, 8'h00);
      check8("rst_io_data", io_data3, 8'h00);
      check8("rst_io_wr", {7'd0, io_wr0}, 8'h00);
      rst = 1'b1;

      preload(14'h0000, 8'h08);
      preload(14'h0123, 8'h6E);
      preload(14'h2005, 8'h11);
      preload(14'h0001, 8'h3A);

      bus_cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 0, 8'h00, got);
      check8("fetch_0000", got, 8'h08);
      bus_cycle(1'b0, 8'h23, 8'h01, 8'h00, 1'b0, 0, 8'h00, got);
      check8("fetch_0123", got, 8'h6E);

      bus_cycle(1'b0, 8'h05, 8'hE0, 8'hA5, 1'b0, 9, 8'h5A, got);
      check8("pcw_d_in", got, 8'h00);
      bus_cycle(1'b0, 8'h05, 8'hA0, 8'h00, 1'b0, 0, 8'h00, got);
      check8("pcw_readback", got, 8'hA5);

      // preload lands mid-delay: the 3-wait responder sees the new byte, the 0-wait one does not
      bus_cycle(1'b0, 8'h23, 8'h81, 8'h00, 1'b0, 2, 8'hC3, got);
      check8("ld_in_delay", got, 8'hC3);

      io_in_data   = 8'hC7;
      io_wr_pulses = 0;
      bus_cycle(1'b0, 8'h3C, 8'h52, 8'h00, 1'b0, 0, 8'h00, got);
      check8("out_io_port", {3'd0, io_port3}, 8'd9);
      check8("out_io_data", io_data3, 8'h3C);
      check8("out_pulses", 8'(io_wr_pulses), 8'd1);
      bus_cycle(1'b0, 8'h00, 8'h44, 8'h00, 1'b0, 0, 8'h00, got);
      check8("inp_d_in", got, 8'hC7);
      check8("inp_io_port", {3'd0, io_port3}, 8'd2);
      check8("inp_no_pulse", 8'(io_wr_pulses), 8'd1);

      pulse_intr();
      check8("intr_raised", {7'd0, intr3}, 8'h01);
      bus_cycle(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 0, 8'h00, got);
      check8("jam_byte", got, 8'h05);
      check8("intr_cleared", {7'd0, intr3}, 8'h00);
      bus_cycle(1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 0, 8'h00, got);
      check8("post_jam_fetch", got, 8'h3A);

      pulse_intr();
      @(negedge clk);
      state = T1; D_out = 8'h05; e_din0_v = 1'b0; e_din3_v = 1'b0;
      @(negedge clk);
      state = T2; D_out = 8'hE0;
      @(negedge clk);
      state = TW; e_ready0 = 1'b1; e_din0 = 8'h00; e_din0_v = 1'b1;
      @(negedge clk);
      check8("pre_rst_ready0", {7'd0, ready0}, 8'h01);
      #2;
      rst = 1'b0;
      m_pending = 1'b0; m_jam = 1'b0; e_ready0 = 1'b0; e_ready3 = 1'b0; e_io_wr = 1'b0;
      e_din0 = 8'h00; e_din3 = 8'h00; e_din0_v = 1'b1; e_din3_v = 1'b1;
      #1;
      check8("mid_rst_ready0", {7'd0, ready0}, 8'h00);
      check8("mid_rst_ready3", {7'd0, ready3}, 8'h00);
      check8("mid_rst_d_in0", d_in0, 8'h00);
      check8("mid_rst_intr", {7'd0, intr3}, 8'h00);
      @(negedge clk);
      state = STOP;
      @(negedge clk);
      rst = 1'b1;
      bus_cycle(1'b0, 8'h05, 8'hA0, 8'h00, 1'b0, 0, 8'h00, got);
      check8("mid_rst_mem_kept", got, 8'hA5);
      check8("intr_lost", {7'd0, intr3}, 8'h00);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
